// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared widths, threshold field positions and reset constants
//            for fifo_umbral.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int DATA_WIDTH = 6;
    localparam int ADDR_WIDTH = 3;
    localparam int CNT_WIDTH  = ADDR_WIDTH + 1;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    localparam int UMB_ALTO_MSB = 7;
    localparam int UMB_ALTO_LSB = 4;
    localparam int UMB_BAJO_MSB = 3;
    localparam int UMB_BAJO_LSB = 0;

    localparam logic [3:0] RST_ALTO = 4'h8;
    localparam logic [3:0] RST_BAJO = 4'h0;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] ptr_t;
    typedef logic [CNT_WIDTH-1:0]  cnt_t;
    typedef logic [3:0]            umb_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_umbral_if.sv
// ============================================================================
// Module   : fifo_umbral_if
// Brief    : Data/status bundle between producer, consumer, control FSM and
//            fifo_umbral.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fifo_umbral_if;
    import fifo_pkg::*;

    logic       active_in;
    logic [7:0] umbrales_I;
    logic       push;
    data_t      data_in;
    logic       pop;
    data_t      data_out;
    logic       valid_out;
    logic       FIFO_empty;
    logic       FIFO_full;
    logic       almost_full;
    logic       almost_empty;
    logic       FIFO_error;

    modport master (
        output active_in, umbrales_I, push, data_in, pop,
        input  data_out, valid_out, FIFO_empty, FIFO_full,
               almost_full, almost_empty, FIFO_error
    );

    modport slave (
        input  active_in, umbrales_I, push, data_in, pop,
        output data_out, valid_out, FIFO_empty, FIFO_full,
               almost_full, almost_empty, FIFO_error
    );

endinterface

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
// Module   : fifo_mem
// Brief    : Register-array storage, synchronous write, registered read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH,
    parameter int ADDR_W = ADDR_WIDTH
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic              i_re,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read samples the pre-write contents, so a same-address write+read returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/fifo_umbral.sv
// ============================================================================
// Module   : fifo_umbral
// Brief    : 8-deep FIFO with registered thresholds and sticky error flag.
//            Optional macro FIFO_ERR_CLR_EN adds the err_clr input.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_umbral
    import fifo_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          reset,
    fifo_umbral_if.slave       bus
`ifdef FIFO_ERR_CLR_EN
    ,
    input  wire logic          err_clr
`endif
);

    ptr_t  r_wr_ptr;
    ptr_t  r_rd_ptr;
    cnt_t  r_cnt;
    cnt_t  w_cnt_nxt;
    umb_t  r_alto;
    umb_t  r_bajo;
    umb_t  w_alto_nxt;
    umb_t  w_bajo_nxt;
    logic  r_empty;
    logic  r_full;
    logic  r_afull;
    logic  r_aempty;
    logic  r_err;
    logic  w_err_nxt;
    logic  r_valid;
    logic  w_push_acc;
    logic  w_pop_acc;
    logic  w_ovf;
    logic  w_udf;
    data_t w_rdata;

    assign w_pop_acc  = bus.pop & ~r_empty;
    assign w_push_acc = bus.push & (~r_full | w_pop_acc);
    assign w_ovf      = bus.push & ~w_push_acc;
    assign w_udf      = bus.pop & r_empty;

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push_acc, w_pop_acc})
            2'b10:   w_cnt_nxt = r_cnt + cnt_t'(1);
            2'b01:   w_cnt_nxt = r_cnt - cnt_t'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    assign w_alto_nxt = bus.active_in ? r_alto : bus.umbrales_I[UMB_ALTO_MSB:UMB_ALTO_LSB];
    assign w_bajo_nxt = bus.active_in ? r_bajo : bus.umbrales_I[UMB_BAJO_MSB:UMB_BAJO_LSB];

`ifdef FIFO_ERR_CLR_EN
    // A fresh error in the clearing cycle keeps the flag set.
    assign w_err_nxt = w_ovf | w_udf | (r_err & ~err_clr);
`else
    assign w_err_nxt = w_ovf | w_udf | r_err;
`endif

    // Flags are computed from next count and next thresholds so they always agree with both.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_alto   <= RST_ALTO;
            r_bajo   <= RST_BAJO;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop_acc) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_cnt    <= w_cnt_nxt;
            r_alto   <= w_alto_nxt;
            r_bajo   <= w_bajo_nxt;
            r_empty  <= (w_cnt_nxt == '0);
            r_full   <= (w_cnt_nxt == cnt_t'(DEPTH));
            r_afull  <= (w_cnt_nxt >= w_alto_nxt);
            r_aempty <= (w_cnt_nxt <= w_bajo_nxt);
            r_err    <= w_err_nxt;
            r_valid  <= w_pop_acc;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_WIDTH),
        .ADDR_W (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_push_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.data_in),
        .i_re    (w_pop_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign bus.data_out     = w_rdata;
    assign bus.valid_out    = r_valid;
    assign bus.FIFO_empty   = r_empty;
    assign bus.FIFO_full    = r_full;
    assign bus.almost_full  = r_afull;
    assign bus.almost_empty = r_aempty;
    assign bus.FIFO_error   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fifo_umbral.sv
// ============================================================================
// Module   : tb_fifo_umbral
// Brief    : Directed bench for fifo_umbral with a queue-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_umbral;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_umbral_if bus();

`ifdef FIFO_ERR_CLR_EN
    logic err_clr = 1'b0;
`endif

    fifo_umbral dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus)
`ifdef FIFO_ERR_CLR_EN
        ,
        .err_clr (err_clr)
`endif
    );

    int checks = 0;
    int errs   = 0;
    bit chk_en = 1'b0;

    logic [5:0] q[$];
    logic [3:0] m_alto;
    logic [3:0] m_bajo;
    logic       m_err;
    logic       m_valid;
    logic [5:0] m_dout;
    bit         m_pop_ok;
    bit         m_push_ok;
    bit         m_ev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy is the queue length, flags follow directly from it.
    initial forever begin
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_alto  = RST_ALTO;
            m_bajo  = RST_BAJO;
            m_err   = 1'b0;
            m_valid = 1'b0;
            m_dout  = '0;
        end else begin
            m_pop_ok  = bus.pop && (q.size() != 0);
            m_push_ok = bus.push && ((q.size() < 8) || m_pop_ok);
            m_ev      = (bus.pop && q.size() == 0) || (bus.push && !m_push_ok);
`ifdef FIFO_ERR_CLR_EN
            if (err_clr) m_err = 1'b0;
`endif
            if (m_ev) m_err = 1'b1;
            m_valid = m_pop_ok;
            if (m_pop_ok) m_dout = q.pop_front();
            if (m_push_ok) q.push_back(bus.data_in);
            if (!bus.active_in) begin
                m_alto = bus.umbrales_I[7:4];
                m_bajo = bus.umbrales_I[3:0];
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("valid_out",    bus.valid_out,    m_valid);
            check("data_out",     bus.data_out,     m_dout);
            check("FIFO_empty",   bus.FIFO_empty,   q.size() == 0);
            check("FIFO_full",    bus.FIFO_full,    q.size() == 8);
            check("almost_full",  bus.almost_full,  q.size() >= int'(m_alto));
            check("almost_empty", bus.almost_empty, q.size() <= int'(m_bajo));
            check("FIFO_error",   bus.FIFO_error,   m_err);
        end
    end

    task automatic cyc(input logic ph, input logic [5:0] d, input logic pp);
        bus.push    = ph;
        bus.data_in = d;
        bus.pop     = pp;
        @(posedge clk);
        @(negedge clk);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    logic op_push [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic op_pop  [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        reset          = 1'b1;
        bus.active_in  = 1'b0;
        bus.umbrales_I = 8'h62;
        bus.push       = 1'b0;
        bus.pop        = 1'b0;
        bus.data_in    = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_empty",  bus.FIFO_empty,   1);
        check("rst_aempty", bus.almost_empty, 1);
        check("rst_afull",  bus.almost_full,  0);
        check("rst_err",    bus.FIFO_error,   0);
        check("rst_valid",  bus.valid_out,    0);
        check("rst_dout",   bus.data_out,     0);
        reset = 1'b0;
        cyc(0, 0, 0);
        check("thr_aempty", bus.almost_empty, 1);

        for (int k = 1; k <= 8; k++) begin
            cyc(1, 6'(k), 0);
            check("fill_afull",  bus.almost_full,  k >= 6);
            check("fill_aempty", bus.almost_empty, k <= 2);
            check("fill_full",   bus.FIFO_full,    k == 8);
        end
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 1);
            check("drain_valid", bus.valid_out,  1);
            check("drain_data",  bus.data_out,   k);
            check("drain_empty", bus.FIFO_empty, k == 8);
        end
        cyc(0, 0, 0);
        check("idle_valid", bus.valid_out, 0);
        check("idle_hold",  bus.data_out,  8);

        for (int k = 1; k <= 8; k++) cyc(1, 6'(8'h10 + k), 0);
        cyc(1, 6'h3F, 0);
        check("ovf_err",  bus.FIFO_error, 1);
        check("ovf_full", bus.FIFO_full,  1);
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 0);
            check("ovf_sticky", bus.FIFO_error, 1);
        end
        for (int k = 1; k <= 4; k++) begin
            cyc(0, 0, 1);
            check("ovf_drain", bus.data_out, 8'h10 + k);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("mrst_empty", bus.FIFO_empty, 1);
        check("mrst_err",   bus.FIFO_error, 0);
        check("mrst_dout",  bus.data_out,   0);
        cyc(0, 0, 0);

        for (int k = 1; k <= 8; k++) cyc(1, 6'(8'h20 + k), 0);
        cyc(1, 6'h30, 1);
        check("full_pp_valid", bus.valid_out,  1);
        check("full_pp_data",  bus.data_out,   8'h21);
        check("full_pp_full",  bus.FIFO_full,  1);
        check("full_pp_err",   bus.FIFO_error, 0);

        for (int i = 0; i < 12; i++) cyc(op_push[i], 6'(8'h31 + i), op_pop[i]);
        for (int n = 0; n < 20 && q.size() > 0; n++) cyc(0, 0, 1);
        cyc(0, 0, 0);
        check("mixed_empty", bus.FIFO_empty, 1);

        cyc(1, 6'h2A, 1);
        check("empty_pp_empty", bus.FIFO_empty, 0);
        check("empty_pp_err",   bus.FIFO_error, 1);
        check("empty_pp_valid", bus.valid_out,  0);

        bus.active_in  = 1'b1;
        bus.umbrales_I = 8'h11;
        cyc(1, 6'h01, 0);
        check("frz_aempty", bus.almost_empty, 1);
        for (int k = 0; k < 3; k++) cyc(1, 6'(8'h02 + k), 0);
        check("frz_afull5", bus.almost_full, 0);
        cyc(1, 6'h05, 0);
        check("frz_afull6", bus.almost_full, 1);
`ifdef FIFO_ERR_CLR_EN
        err_clr = 1'b1;
        cyc(0, 0, 0);
        err_clr = 1'b0;
        check("err_clr", bus.FIFO_error, 0);
`endif
        bus.active_in = 1'b0;
        cyc(0, 0, 0);
        check("unfrz_afull",  bus.almost_full,  1);
        check("unfrz_aempty", bus.almost_empty, 0);
        bus.umbrales_I = 8'h08;
        cyc(0, 0, 0);
        check("alto0_afull",  bus.almost_full,  1);
        check("bajo8_aempty", bus.almost_empty, 1);
        for (int n = 0; n < 20 && q.size() > 0; n++) cyc(0, 0, 1);
        cyc(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
